// File: rtl/json_number_pkg.sv
// json_number_pkg: shared states, error codes and character helpers for the number builder.
package json_number_pkg;
    typedef enum logic [3:0] {
        S_IDLE, S_SIGN, S_INT_ZERO, S_INT, S_FRAC_FIRST, S_FRAC,
        S_EXP_SIGN, S_EXP_FIRST, S_EXP, S_HOLD
    } state_t;

    typedef enum logic [2:0] {
        ERR_NONE    = 3'd0,
        ERR_GRAMMAR = 3'd1,
        ERR_INT_OVF = 3'd2,
        ERR_EXP_OVF = 3'd3,
        ERR_TRUNC   = 3'd4
    } err_t;

    localparam logic [7:0] CH_MINUS = 8'h2D;
    localparam logic [7:0] CH_PLUS  = 8'h2B;
    localparam logic [7:0] CH_DOT   = 8'h2E;
    localparam logic [7:0] CH_E     = 8'h45;
    localparam logic [7:0] CH_e     = 8'h65;
    localparam logic [7:0] CH_0     = 8'h30;
    localparam logic [7:0] CH_9     = 8'h39;

    function automatic logic is_digit(input logic [7:0] c);
        return (c >= CH_0) && (c <= CH_9);
    endfunction
endpackage

// File: rtl/decimal_accumulator.sv
// decimal_accumulator: keeps up to MAX_DIGITS decimal digits as a binary value.
// Digits past the limit are dropped and flagged; clear with enable restarts from this digit.
module decimal_accumulator #(
    parameter int WIDTH      = 64,
    parameter int MAX_DIGITS = 19,
    parameter int CNT_W      = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             enable,
    input  logic [3:0]       digit,
    output logic [WIDTH-1:0] value,
    output logic [CNT_W-1:0] count,
    output logic             overflow
);
    logic [WIDTH-1:0] r_value;
    logic [CNT_W-1:0] r_count;
    logic             r_ovf;
    logic [WIDTH-1:0] w_val;
    logic [CNT_W-1:0] w_cnt;
    logic             w_ovf;
    logic             w_take;

    assign w_val  = clear ? '0 : r_value;
    assign w_cnt  = clear ? '0 : r_count;
    assign w_ovf  = clear ? 1'b0 : r_ovf;
    assign w_take = enable && (w_cnt < CNT_W'(MAX_DIGITS));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_value <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else if (clear || enable) begin
            r_value <= w_take ? (w_val << 3) + (w_val << 1) + {{(WIDTH-4){1'b0}}, digit} : w_val;
            r_count <= w_take ? w_cnt + 1'b1 : w_cnt;
            r_ovf   <= w_ovf || (enable && !w_take);
        end
    end

    assign value    = r_value;
    assign count    = r_count;
    assign overflow = r_ovf;
endmodule

// File: rtl/json_number_stream_builder.sv
// json_number_stream_builder: validates a JSON number token one character per cycle
// and holds a single integer or float-segment record until downstream takes it.
module json_number_stream_builder
    import json_number_pkg::*;
#(
    parameter int WIDTH      = 64,
    parameter int MAX_DIGITS = 19,
    parameter int CNT_W      = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_char,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] tape_entry,
    output logic             is_float,
    output logic [WIDTH-1:0] frac_part,
    output logic [CNT_W-1:0] frac_digits,
    output logic [WIDTH-1:0] exp_part,
    output logic             exp_neg,
    output logic             num_neg,
    output logic             error,
    output logic [2:0]       err_code
);
    localparam logic [WIDTH-1:0] POS_LIM = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] NEG_LIM = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           r_state;
    logic             r_neg, r_eneg, r_flt, r_gram;
    state_t           w_cur, w_nxt;
    logic             w_acc, w_clr, w_g, w_go, w_bad, w_dig, w_e;
    logic             w_int_en, w_frac_en, w_exp_en, w_set_neg, w_set_eneg, w_set_flt;
    logic [WIDTH-1:0] w_int_val, w_exp_val;
    logic [CNT_W-1:0] w_int_cnt, w_exp_cnt;
    logic             w_int_cov, w_frac_cov, w_exp_cov, w_int_ovf, w_exp_ovf;
    err_t             w_err;
    logic             w_unused;

    assign out_valid = r_state == S_HOLD;
    assign in_ready  = !out_valid || out_ready;
    assign w_acc     = in_valid && in_ready;
    assign w_clr     = out_valid && out_ready;
    // A character taken while the record drains is the first character of the next token.
    assign w_cur     = out_valid ? S_IDLE : r_state;
    assign w_g       = r_gram && !out_valid;
    assign w_go      = w_acc && !w_g && !w_bad;
    assign w_dig     = is_digit(in_char);
    assign w_e       = (in_char == CH_E) || (in_char == CH_e);

    always_comb begin
        w_nxt      = w_cur;
        w_bad      = 1'b0;
        w_int_en   = 1'b0;
        w_frac_en  = 1'b0;
        w_exp_en   = 1'b0;
        w_set_neg  = 1'b0;
        w_set_eneg = 1'b0;
        w_set_flt  = 1'b0;
        case (w_cur)
            S_IDLE, S_SIGN: begin
                if (w_cur == S_IDLE && in_char == CH_MINUS) begin
                    w_nxt     = S_SIGN;
                    w_set_neg = 1'b1;
                end else if (in_char == CH_0) w_nxt = S_INT_ZERO;
                else if (w_dig) begin
                    w_nxt    = S_INT;
                    w_int_en = 1'b1;
                end else w_bad = 1'b1;
            end
            S_INT_ZERO, S_INT: begin
                if (w_dig && w_cur == S_INT) w_int_en = 1'b1;
                else if (in_char == CH_DOT) begin
                    w_nxt     = S_FRAC_FIRST;
                    w_set_flt = 1'b1;
                end else if (w_e) begin
                    w_nxt     = S_EXP_SIGN;
                    w_set_flt = 1'b1;
                end else w_bad = 1'b1;
            end
            S_FRAC_FIRST, S_FRAC: begin
                if (w_dig) begin
                    w_nxt     = S_FRAC;
                    w_frac_en = 1'b1;
                end else if (w_e && w_cur == S_FRAC) w_nxt = S_EXP_SIGN;
                else w_bad = 1'b1;
            end
            S_EXP_SIGN: begin
                if (in_char == CH_PLUS || in_char == CH_MINUS) begin
                    w_nxt      = S_EXP_FIRST;
                    w_set_eneg = in_char == CH_MINUS;
                end else if (w_dig) begin
                    w_nxt    = S_EXP;
                    w_exp_en = 1'b1;
                end else w_bad = 1'b1;
            end
            S_EXP_FIRST, S_EXP: begin
                if (w_dig) begin
                    w_nxt    = S_EXP;
                    w_exp_en = 1'b1;
                end else w_bad = 1'b1;
            end
            default: w_bad = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_neg   <= 1'b0;
            r_eneg  <= 1'b0;
            r_flt   <= 1'b0;
            r_gram  <= 1'b0;
        end else begin
            if (w_acc) r_state <= in_last ? S_HOLD : (w_g || w_bad) ? w_cur : w_nxt;
            else if (w_clr) r_state <= S_IDLE;
            r_neg  <= (r_neg && !w_clr) || (w_go && w_set_neg);
            r_eneg <= (r_eneg && !w_clr) || (w_go && w_set_eneg);
            r_flt  <= (r_flt && !w_clr) || (w_go && w_set_flt);
            if (w_acc)
                r_gram <= w_g || w_bad ||
                          (in_last && (w_nxt inside {S_SIGN, S_FRAC_FIRST, S_EXP_SIGN, S_EXP_FIRST}));
            else if (w_clr) r_gram <= 1'b0;
        end
    end

    decimal_accumulator #(.WIDTH(WIDTH), .MAX_DIGITS(MAX_DIGITS), .CNT_W(CNT_W)) u_int (
        .clk(clk), .rst_n(rst_n), .clear(w_clr), .enable(w_go && w_int_en), .digit(in_char[3:0]),
        .value(w_int_val), .count(w_int_cnt), .overflow(w_int_cov)
    );
    decimal_accumulator #(.WIDTH(WIDTH), .MAX_DIGITS(MAX_DIGITS), .CNT_W(CNT_W)) u_frac (
        .clk(clk), .rst_n(rst_n), .clear(w_clr), .enable(w_go && w_frac_en), .digit(in_char[3:0]),
        .value(frac_part), .count(frac_digits), .overflow(w_frac_cov)
    );
    decimal_accumulator #(.WIDTH(WIDTH), .MAX_DIGITS(MAX_DIGITS), .CNT_W(CNT_W)) u_exp (
        .clk(clk), .rst_n(rst_n), .clear(w_clr), .enable(w_go && w_exp_en), .digit(in_char[3:0]),
        .value(w_exp_val), .count(w_exp_cnt), .overflow(w_exp_cov)
    );

    // Range check on the signed result applies to integers; floats carry an unsigned magnitude.
    assign w_int_ovf = w_int_cov || (!r_flt && (r_neg ? w_int_val > NEG_LIM : w_int_val > POS_LIM));
    assign w_exp_ovf = w_exp_cov || (w_exp_val > POS_LIM);
    assign w_err     = r_gram ? ERR_GRAMMAR : w_int_ovf ? ERR_INT_OVF : w_exp_ovf ? ERR_EXP_OVF :
                       w_frac_cov ? ERR_TRUNC : ERR_NONE;

    assign tape_entry = w_int_ovf ? (r_neg ? NEG_LIM : POS_LIM) :
                        (r_neg && !r_flt) ? -w_int_val : w_int_val;
    assign is_float   = r_flt;
    assign exp_part   = w_exp_val;
    assign exp_neg    = r_eneg;
    assign num_neg    = r_neg;
    assign err_code   = w_err;
    assign error      = (w_err != ERR_NONE) && (w_err != ERR_TRUNC);
    assign w_unused   = &{1'b0, w_int_cnt, w_exp_cnt};
endmodule

// File: tb/tb_json_number_stream_builder.sv
// tb_json_number_stream_builder: directed and random tokens checked against a string-level JSON number model.
module tb_json_number_stream_builder;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, in_last, out_valid, out_ready;
    logic [7:0]  in_char;
    logic [63:0] tape_entry, frac_part, exp_part;
    logic        is_float, exp_neg, num_neg, error;
    logic [4:0]  frac_digits;
    logic [2:0]  err_code;
    int          ncmp = 0;
    int          nerr = 0;

    localparam logic [63:0] PMAX = 64'h7FFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] NMIN = 64'h8000_0000_0000_0000;

    typedef struct {
        logic [63:0] tape;
        logic        flt;
        logic [63:0] frac;
        logic [4:0]  fd;
        logic [63:0] ex;
        logic        eneg;
        logic        neg;
        logic        err;
        logic [2:0]  code;
    } rec_t;

    json_number_stream_builder dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_char(in_char),
        .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .tape_entry(tape_entry),
        .is_float(is_float), .frac_part(frac_part), .frac_digits(frac_digits), .exp_part(exp_part),
        .exp_neg(exp_neg), .num_neg(num_neg), .error(error), .err_code(err_code)
    );

    always #5 clk = ~clk;

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic bit isd(byte c);
        return c >= 8'h30 && c <= 8'h39;
    endfunction

    // Value of the first (at most 19) digits of s[st +: n].
    function automatic logic [63:0] dec(string s, int st, int n);
        logic [63:0] v = 0;
        for (int k = 0; k < n && k < 19; k++) v = v * 10 + 64'(s[st+k] - 8'h30);
        return v;
    endfunction

    function automatic rec_t model(string s);
        rec_t r;
        int i = 0, n = s.len(), is, fs = 0, es = 0, ni, nf = 0, ne = 0;
        bit ok = 1, iovf, eovf;
        logic [63:0] iv;
        r = '{default: '0};
        if (s[0] == 8'h2D) begin r.neg = 1; i = 1; end
        is = i;
        while (i < n && isd(s[i])) i++;
        ni = i - is;
        if (ni == 0 || (ni > 1 && s[is] == 8'h30)) ok = 0;
        if (i < n && s[i] == 8'h2E) begin
            r.flt = 1; i++; fs = i;
            while (i < n && isd(s[i])) i++;
            nf = i - fs;
            if (nf == 0) ok = 0;
        end
        if (i < n && (s[i] == 8'h45 || s[i] == 8'h65)) begin
            r.flt = 1; i++;
            if (i < n && (s[i] == 8'h2B || s[i] == 8'h2D)) begin r.eneg = s[i] == 8'h2D; i++; end
            es = i;
            while (i < n && isd(s[i])) i++;
            ne = i - es;
            if (ne == 0) ok = 0;
        end
        if (i != n) ok = 0;
        iv     = dec(s, is, ni);
        r.frac = dec(s, fs, nf);
        r.fd   = 5'(nf > 19 ? 19 : nf);
        r.ex   = dec(s, es, ne);
        iovf   = ni > 19 || (!r.flt && (r.neg ? iv > NMIN : iv > PMAX));
        eovf   = ne > 19 || r.ex > PMAX;
        r.tape = iovf ? (r.neg ? NMIN : PMAX) : (r.neg && !r.flt) ? -iv : iv;
        r.code = !ok ? 3'd1 : iovf ? 3'd2 : eovf ? 3'd3 : nf > 19 ? 3'd4 : 3'd0;
        r.err  = r.code inside {3'd1, 3'd2, 3'd3};
        return r;
    endfunction

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        ncmp++;
        assert (got === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_rec(rec_t e);
        chk("out_valid", out_valid, 1);
        chk("error", error, e.err);
        chk("err_code", err_code, e.code);
        if (e.code != 3'd1) begin
            chk("tape_entry", tape_entry, e.tape);
            chk("is_float", is_float, e.flt);
            chk("frac_part", frac_part, e.frac);
            chk("frac_digits", frac_digits, e.fd);
            chk("exp_part", exp_part, e.ex);
            chk("exp_neg", exp_neg, e.eneg);
            chk("num_neg", num_neg, e.neg);
        end
    endtask

    // Back-to-back characters; returns at the negedge after the last beat's accepting edge.
    task automatic send(string s);
        for (int k = 0; k < s.len(); k++) begin
            @(negedge clk);
            chk("in_ready_tok", in_ready, 1);
            in_valid = 1;
            in_char  = s[k];
            in_last  = k == s.len() - 1;
        end
        @(negedge clk);
        in_valid = 0;
        in_last  = 0;
        chk("latency", out_valid, 1);
    endtask

    task automatic drain();
        out_ready = 1;
        @(negedge clk);
        out_ready = 0;
        chk("drained", out_valid, 0);
    endtask

    task automatic run(string s);
        rec_t e = model(s);
        send(s);
        check_rec(e);
        repeat ($urandom_range(0, 3)) begin
            @(negedge clk);
            chk("in_ready_hold", in_ready, 0);
            check_rec(e);
        end
        drain();
    endtask

    function automatic string rdig(int n, bit nz);
        string digs = "0123456789", t = "";
        for (int k = 0; k < n; k++) begin
            int d = (k == 0 && nz) ? $urandom_range(1, 9) : $urandom_range(0, 9);
            t = {t, digs.substr(d, d)};
        end
        return t;
    endfunction

    function automatic string gen();
        string s = "", bad = "0.-+eEx";
        int ni, nf, ne, r;
        bit flt, dot;
        if ($urandom_range(0, 3) == 0) s = "-";
        r   = $urandom_range(0, 9);
        ni  = r < 6 ? $urandom_range(1, 6) : r < 9 ? $urandom_range(17, 19) : $urandom_range(20, 21);
        flt = $urandom_range(0, 1) == 1;
        if (flt && ni > 19) ni = 19;
        s = {s, rdig(ni, ni > 1)};
        if (flt) begin
            dot = $urandom_range(0, 1) == 1;
            if (dot) begin
                nf = $urandom_range(0, 9) < 8 ? $urandom_range(1, 6) : $urandom_range(18, 21);
                s = {s, ".", rdig(nf, 0)};
            end
            if (!dot || $urandom_range(0, 1) == 1) begin
                ne = $urandom_range(0, 9) < 8 ? $urandom_range(1, 4) : $urandom_range(19, 20);
                r = $urandom_range(0, 2);
                s = {s, $urandom_range(0, 1) ? "e" : "E", r == 0 ? "" : r == 1 ? "+" : "-", rdig(ne, ne >= 19)};
            end
        end
        if ($urandom_range(0, 5) == 0) s.putc($urandom_range(0, s.len() - 1), bad.getc($urandom_range(0, 6)));
        if ($urandom_range(0, 9) == 0 && s.len() > 1) s = s.substr(0, s.len() - 2);
        return s;
    endfunction

    initial begin
        string bad_toks[4] = '{"01", "1.", "-", "1e+"};
        rst_n = 0; in_valid = 0; in_char = 0; in_last = 0; out_ready = 0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_tape", tape_entry, 0);
        chk("rst_error", error, 0);
        chk("rst_err_code", err_code, 0);
        chk("rst_is_float", is_float, 0);
        rst_n = 1;

        send("12345");
        chk("d_12345", tape_entry, 64'd12345);
        chk("d_12345_flt", is_float, 0);
        chk("d_12345_err", error, 0);
        drain();

        send("-9223372036854775808");
        chk("d_min", tape_entry, NMIN);
        chk("d_min_err", error, 0);
        drain();

        send("9223372036854775808");
        chk("d_sat", tape_entry, PMAX);
        chk("d_sat_code", err_code, 3'd2);
        chk("d_sat_err", error, 1);
        drain();

        send("-3.1415e-10");
        chk("d_flt", is_float, 1);
        chk("d_flt_tape", tape_entry, 64'd3);
        chk("d_flt_frac", frac_part, 64'd1415);
        chk("d_flt_fd", frac_digits, 5'd4);
        chk("d_flt_exp", exp_part, 64'd10);
        chk("d_flt_eneg", exp_neg, 1);
        chk("d_flt_neg", num_neg, 1);
        chk("d_flt_err", error, 0);
        drain();

        foreach (bad_toks[k]) begin
            send(bad_toks[k]);
            chk("d_gram_err", error, 1);
            chk("d_gram_code", err_code, 3'd1);
            drain();
        end
        send("7");
        chk("d_7", tape_entry, 64'd7);
        chk("d_7_err", error, 0);
        drain();

        send("42");
        repeat (5) begin
            @(negedge clk);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_valid", out_valid, 1);
            chk("bp_tape", tape_entry, 64'd42);
        end
        out_ready = 1; in_valid = 1; in_char = "9"; in_last = 1;
        #1 chk("bp_same_cycle_ready", in_ready, 1);
        @(negedge clk);
        in_valid = 0; in_last = 0; out_ready = 0;
        chk("bp_next_valid", out_valid, 1);
        chk("bp_next_tape", tape_entry, 64'd9);
        drain();

        @(negedge clk);
        in_valid = 1; in_char = "1"; in_last = 0;
        @(negedge clk);
        in_char = "2";
        @(negedge clk);
        in_valid = 0; rst_n = 0;
        #1 chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_tape", tape_entry, 0);
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        chk("mid_rst_no_rec", out_valid, 0);
        send("5");
        chk("d_5", tape_entry, 64'd5);
        drain();

        repeat (150) run(gen());

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
